// File: rtl/rambus_arbiter.sv
// Round-robin Wishbone arbiter sharing one OpenRAM rambus port between N_REQ masters.
// A granted master holds the bus for its whole cyc; a watchdog aborts transfers that never see ack.
module rambus_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic [N_REQ-1:0]        req_cyc_i,
    input  logic [N_REQ-1:0]        req_stb_i,
    input  logic [N_REQ-1:0]        req_we_i,
    input  logic [4*N_REQ-1:0]      req_sel_i,
    input  logic [32*N_REQ-1:0]     req_dat_i,
    input  logic [ADDR_W*N_REQ-1:0] req_adr_i,
    output logic [N_REQ-1:0]        req_ack_o,
    output logic [N_REQ-1:0]        req_err_o,
    output logic [31:0]             req_dat_o,
    output logic                    ram_cyc_o,
    output logic                    ram_stb_o,
    output logic                    ram_we_o,
    output logic [3:0]              ram_sel_o,
    output logic [31:0]             ram_dat_o,
    output logic [ADDR_W-1:0]       ram_adr_o,
    input  logic                    ram_ack_i,
    input  logic [31:0]             ram_dat_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TMR_W = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [TMR_W-1:0]   timer_q, timer_d;

    logic [N_REQ-1:0]   request;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;

    logic               g_cyc, g_stb, g_we;
    logic [3:0]         g_sel;
    logic [31:0]        g_dat;
    logic [ADDR_W-1:0]  g_adr;

    // Round-robin search from last+1; walking backwards lets the nearest requester win.
    always_comb begin
        int unsigned cand;
        request    = req_cyc_i & req_stb_i;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = N_REQ; i >= 1; i--) begin
            cand = (int'(last_q) + i) % N_REQ;
            if (request[IDX_W'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // One-hot AND-OR mux of the granted master's bus signals.
    always_comb begin
        g_cyc = |(req_cyc_i & grant_q);
        g_stb = |(req_stb_i & grant_q);
        g_we  = |(req_we_i & grant_q);
        g_sel = '0;
        g_dat = '0;
        g_adr = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            g_sel = g_sel | (req_sel_i[4*k +: 4] & {4{grant_q[k]}});
            g_dat = g_dat | (req_dat_i[32*k +: 32] & {32{grant_q[k]}});
            g_adr = g_adr | (req_adr_i[ADDR_W*k +: ADDR_W] & {ADDR_W{grant_q[k]}});
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        last_d    = last_q;
        timer_d   = '0;
        req_ack_o = '0;
        req_err_o = '0;
        req_dat_o = '0;
        ram_cyc_o = 1'b0;
        ram_stb_o = 1'b0;
        ram_we_o  = 1'b0;
        ram_sel_o = '0;
        ram_dat_o = '0;
        ram_adr_o = '0;
        busy_o    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = OWN;
                    grant_d = ONE_HOT0 << pick_idx;
                    idx_d   = pick_idx;
                end
            end
            OWN: begin
                busy_o    = 1'b1;
                ram_cyc_o = g_cyc;
                ram_stb_o = g_stb;
                ram_we_o  = g_we;
                ram_sel_o = g_sel;
                ram_dat_o = g_dat;
                ram_adr_o = g_adr;
                req_ack_o = grant_q & {N_REQ{ram_ack_i}};
                req_dat_o = ram_dat_i;
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = idx_q;
                end else if (g_stb && !ram_ack_i) begin
                    // Ack on the final stalled cycle is handled above: it never reaches here.
                    if (timer_q == TMR_LAST) begin
                        state_d = ABORT;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            ABORT: begin
                busy_o    = 1'b1;
                req_err_o = grant_q;
                req_dat_o = ERR_DATA;
                state_d   = IDLE;
                grant_d   = '0;
                last_d    = idx_q;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IDX_LAST;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            timer_q <= timer_d;
        end
    end

    assign grant_o = grant_q;

endmodule
